rv32_hart_fetch: RTL and testbench
==================================

# rv32_hart_fetch

Parametrised multi-hart instruction fetch unit for the pito barrel core. Holds one program counter per hart, selects a hart each cycle round-robin over an enable mask, drives the instruction BRAM read port, and presents instruction, PC and hart ID to the decode stage. It replaces the single-PC fetch path: it adds per-hart redirects, stall back-pressure, hart masking and squashing of the in-flight slot.

## Interface
- NUM_HARTS, 8, number of hardware threads (power of two, 1..32)
- PC_W, 32, program counter width
- IMEM_ADDR_W, 12, instruction BRAM word-address width
- RESET_ADDR, 32'h0, reset PC for every hart (word-aligned)
- rv32_io_clk  in  1  single clock; all logic on rising edge
- rv32_io_rst  in  1  reset, synchronous, active-high
- rv32_io_program  in  1  BRAM programming in progress; fetch suspended
- hart_en  in  NUM_HARTS  per-hart enable mask
- stall  in  1  decode cannot accept; hold output slot
- redir_valid  in  1  branch/jump resolved in execute
- redir_hart  in  log2(NUM_HARTS)  hart to redirect
- redir_pc  in  PC_W  redirect target
- imem_raddr  out  IMEM_ADDR_W  BRAM read word address
- imem_rdata  in  32  BRAM read data, 1-cycle latency
- f_valid  out  1  output slot holds a live instruction
- f_instr  out  32  instruction (driven from imem_rdata)
- f_pc  out  PC_W  PC of f_instr
- f_hart  out  log2(NUM_HARTS)  hart of f_instr
- f_misalign  out  1  redirect target had pc[1:0] != 0

## Operation
- State: pc[NUM_HARTS], last-issued pointer rr, slot registers (valid, pc, hart, misalign).
- Issue: when not stalled, not programming, and any hart_en bit set, select first enabled hart after rr (circular); imem_raddr = pc[h][IMEM_ADDR_W+1:2]; pc[h] += 4 (wraps modulo 2^PC_W); rr = h; slot loads {1, pc, h}.
- No issue (no enabled hart or programming): slot valid loads 0; pc and rr unchanged.
- Redirect: pc[redir_hart] = {redir_pc[PC_W-1:2], 2'b00}; misalign recorded for that hart's next issue then cleared.
- Redirect same cycle as issue of same hart: redirect wins; issue uses the redirect target (bypass), pc becomes target+4.
- Redirect hart equals hart in current slot: slot valid cleared next edge (squash), even while stalled.
- Stall: imem_raddr, rr, slot held so f_instr stays stable; redirects still update pc.
- rv32_io_program rising mid-operation: in-flight slot completes one cycle, then f_valid = 0 until it falls; PCs retained.

## Timing
- Reset values: all pc = RESET_ADDR, rr = NUM_HARTS-1 (first issue is hart 0), f_valid = 0, f_pc = RESET_ADDR, f_hart = 0, f_misalign = 0, imem_raddr = 0.
- Latency: issue at edge t; f_valid/f_instr/f_pc/f_hart valid during cycle t+1.
- Throughput: one instruction per cycle when unstalled; with k enabled harts each hart fetches every k cycles.
- Handshake: slot consumed on any cycle with f_valid=1 and stall=0.
- hart_en change takes effect at the next issue decision; an already-issued slot is not squashed.

## Configuration
- RV32_FETCH_PERF_EN defined: per-hart 32-bit fetch counters (increment on consumed slot, saturating at 2^32-1) plus stall-cycle counter, exposed on output port perf_fetch_cnt (NUM_HARTS×32) and perf_stall_cnt (32); reset to 0.
- Undefined: counters and ports absent; behaviour otherwise identical.

## Structure
- Shared package: hart_id_t, rv_pc_cnt_t parametrised widths, RESET_ADDR default, fetch slot struct {valid, pc, hart, misalign}.
- One sub-module: rv32_rr_arbiter (NUM_HARTS requests, pointer in, one-hot grant and encoded index out, combinational).

## Test plan
- Reset, hart_en=8'hFF, imem word n = n: f_hart 0,1,…,7,0 on consecutive cycles; f_pc 0×8 then 4×8.
- hart_en=8'b0000_0101: only harts 0 and 2 alternate; hart 2 pc advances 0,4,8.
- Redirect hart 3 to 0x100 while hart 3 in slot: that slot f_valid=0; hart 3's next fetch f_pc=0x100, imem_raddr=0x40.
- Redirect hart 0 to 0x202 same cycle hart 0 issues: f_pc=0x200, f_misalign=1, next hart-0 pc 0x204.
- stall high 5 cycles: f_instr/f_pc/f_hart constant, no pc advances; release resumes with next hart.
- rv32_io_program high 10 cycles mid-run: f_valid=0 throughout after one drain cycle; PCs resume unchanged.

Source files
------------

// File: rtl/rv32_hart_fetch_pkg.sv
// Shared types and defaults for the multi-hart fetch unit and its arbiter.
package rv32_hart_fetch_pkg;

  localparam int DEF_NUM_HARTS = 8;
  localparam int DEF_PC_W = 32;
  localparam int DEF_IMEM_ADDR_W = 12;
  localparam logic [31:0] DEF_RESET_ADDR = 32'h0;
  localparam int DEF_HART_W = $clog2(DEF_NUM_HARTS);

  typedef logic [DEF_HART_W-1:0] hart_id_t;
  typedef logic [DEF_PC_W-1:0] rv_pc_cnt_t;

  typedef struct packed {
    logic       valid;
    rv_pc_cnt_t pc;
    hart_id_t   hart;
    logic       misalign;
  } fetch_slot_t;

  // A single-hart build still needs a 1-bit hart index.
  function automatic int hart_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv32_hart_fetch_if.sv
// Fetch-unit bus: control inputs, instruction BRAM read port and decode-side slot.
interface rv32_hart_fetch_if
  import rv32_hart_fetch_pkg::*;
#(
  parameter int NUM_HARTS   = DEF_NUM_HARTS,
  parameter int PC_W        = DEF_PC_W,
  parameter int IMEM_ADDR_W = DEF_IMEM_ADDR_W
) ();

  localparam int HART_W = hart_w(NUM_HARTS);

  logic [NUM_HARTS-1:0]   hart_en;
  logic                   stall;
  logic                   redir_valid;
  logic [HART_W-1:0]      redir_hart;
  logic [PC_W-1:0]        redir_pc;
  logic [IMEM_ADDR_W-1:0] imem_raddr;
  logic [31:0]            imem_rdata;
  logic                   f_valid;
  logic [31:0]            f_instr;
  logic [PC_W-1:0]        f_pc;
  logic [HART_W-1:0]      f_hart;
  logic                   f_misalign;

  modport master (
    input  hart_en, stall, redir_valid, redir_hart, redir_pc, imem_rdata,
    output imem_raddr, f_valid, f_instr, f_pc, f_hart, f_misalign
  );

  modport slave (
    output hart_en, stall, redir_valid, redir_hart, redir_pc, imem_rdata,
    input  imem_raddr, f_valid, f_instr, f_pc, f_hart, f_misalign
  );

endinterface

// File: rtl/rv32_hart_fetch_arbiter.sv
// Combinational round-robin arbiter: grants the first request strictly after i_ptr.
module rv32_rr_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    int j;
    j = 0;
    o_grant = '0;
    o_idx = '0;
    o_any = 1'b0;
    // k = NUM_REQ wraps back to i_ptr itself, so a lone requester re-wins.
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[j]) begin
        o_any = 1'b1;
        o_grant[j] = 1'b1;
        o_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/rv32_hart_fetch.sv
// Barrel-core fetch: per-hart PCs, round-robin issue, redirect bypass/squash, stall hold.
// Optional RV32_FETCH_PERF_EN adds per-hart fetch counters and a stall-cycle counter.
module rv32_hart_fetch
  import rv32_hart_fetch_pkg::*;
#(
  parameter int NUM_HARTS   = DEF_NUM_HARTS,
  parameter int PC_W        = DEF_PC_W,
  parameter int IMEM_ADDR_W = DEF_IMEM_ADDR_W,
  parameter logic [PC_W-1:0] RESET_ADDR = PC_W'(DEF_RESET_ADDR)
) (
  input  logic rv32_io_clk,
  input  logic rv32_io_rst,
  input  logic rv32_io_program,
  rv32_hart_fetch_if.master bus
`ifdef RV32_FETCH_PERF_EN
  ,
  output logic [NUM_HARTS*32-1:0] perf_fetch_cnt,
  output logic [31:0]             perf_stall_cnt
`endif
);

  localparam int HART_W = hart_w(NUM_HARTS);

  typedef logic [HART_W-1:0] hid_t;
  typedef logic [PC_W-1:0] pc_t;
  typedef struct packed {
    logic valid;
    pc_t  pc;
    hid_t hart;
    logic misalign;
  } slot_t;

  localparam pc_t PC_STEP = pc_t'(4);

  pc_t                    r_pc [NUM_HARTS];
  logic                   r_mis_pend [NUM_HARTS];
  hid_t                   r_rr;
  logic [IMEM_ADDR_W-1:0] r_raddr;
  slot_t                  r_slot;

  logic [NUM_HARTS-1:0]   w_grant;
  hid_t                   w_sel;
  logic                   w_any;
  logic                   w_issue;
  logic                   w_bypass;
  pc_t                    w_redir_tgt;
  logic                   w_redir_mis;
  pc_t                    w_issue_pc;
  logic                   w_issue_mis;
  logic [IMEM_ADDR_W-1:0] w_issue_addr;
  slot_t                  w_slot_next;

  rv32_rr_arbiter #(
    .NUM_REQ(NUM_HARTS),
    .IDX_W  (HART_W)
  ) u_arb (
    .i_req  (bus.hart_en),
    .i_ptr  (r_rr),
    .o_grant(w_grant),
    .o_idx  (w_sel),
    .o_any  (w_any)
  );

  assign w_redir_tgt  = {bus.redir_pc[PC_W-1:2], 2'b00};
  assign w_redir_mis  = |bus.redir_pc[1:0];
  assign w_issue      = w_any && !bus.stall && !rv32_io_program && !rv32_io_rst;
  // A redirect aimed at the hart being issued this cycle must be fetched from its target.
  assign w_bypass     = bus.redir_valid && (bus.redir_hart == w_sel);
  assign w_issue_pc   = w_bypass ? w_redir_tgt : r_pc[w_sel];
  assign w_issue_mis  = w_bypass ? w_redir_mis : r_mis_pend[w_sel];
  assign w_issue_addr = w_issue_pc[IMEM_ADDR_W+1:2];

  // The BRAM registers its address, so re-presenting the held address keeps f_instr stable.
  assign bus.imem_raddr = w_issue ? w_issue_addr : r_raddr;
  assign bus.f_instr    = bus.imem_rdata;
  assign bus.f_valid    = r_slot.valid;
  assign bus.f_pc       = r_slot.pc;
  assign bus.f_hart     = r_slot.hart;
  assign bus.f_misalign = r_slot.misalign;

  always_comb begin
    w_slot_next = r_slot;
    if (w_issue) begin
      w_slot_next = '{valid: 1'b1, pc: w_issue_pc, hart: w_sel, misalign: w_issue_mis};
    end else if (bus.stall) begin
      if (bus.redir_valid && (bus.redir_hart == r_slot.hart)) begin
        w_slot_next.valid = 1'b0;
      end
    end else begin
      w_slot_next.valid = 1'b0;
    end
  end

  always_ff @(posedge rv32_io_clk) begin
    if (rv32_io_rst) begin
      r_rr    <= hid_t'(NUM_HARTS - 1);
      r_raddr <= '0;
      r_slot  <= '{valid: 1'b0, pc: RESET_ADDR, hart: '0, misalign: 1'b0};
    end else begin
      r_slot <= w_slot_next;
      if (w_issue) begin
        r_rr    <= w_sel;
        r_raddr <= w_issue_addr;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
    logic w_redir_me;
    assign w_redir_me = bus.redir_valid && (bus.redir_hart == hid_t'(gi));

    always_ff @(posedge rv32_io_clk) begin
      if (rv32_io_rst) begin
        r_pc[gi]       <= RESET_ADDR;
        r_mis_pend[gi] <= 1'b0;
      end else if (w_issue && w_grant[gi]) begin
        r_pc[gi]       <= w_issue_pc + PC_STEP;
        r_mis_pend[gi] <= 1'b0;
      end else if (w_redir_me) begin
        r_pc[gi]       <= w_redir_tgt;
        r_mis_pend[gi] <= w_redir_mis;
      end
    end
  end

`ifdef RV32_FETCH_PERF_EN
  logic [31:0] r_fetch_cnt [NUM_HARTS];
  logic [31:0] r_stall_cnt;
  logic        w_consume;

  assign w_consume = r_slot.valid && !bus.stall;

  for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_perf
    always_ff @(posedge rv32_io_clk) begin
      if (rv32_io_rst) begin
        r_fetch_cnt[gi] <= '0;
      end else if (w_consume && (r_slot.hart == hid_t'(gi)) && (r_fetch_cnt[gi] != '1)) begin
        r_fetch_cnt[gi] <= r_fetch_cnt[gi] + 32'd1;
      end
    end
    assign perf_fetch_cnt[gi*32 +: 32] = r_fetch_cnt[gi];
  end

  always_ff @(posedge rv32_io_clk) begin
    if (rv32_io_rst) begin
      r_stall_cnt <= '0;
    end else if (bus.stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_rv32_hart_fetch.sv
// Scoreboard bench for rv32_hart_fetch: a cycle model pushes expected slots, a negedge monitor pops them.
module tb_rv32_hart_fetch;
  import rv32_hart_fetch_pkg::*;

  localparam int NH = 8;

  typedef struct {
    fetch_slot_t s;
    int          due;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic prog = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rv32_hart_fetch_if #(.NUM_HARTS(NH), .PC_W(32), .IMEM_ADDR_W(12)) bus ();

`ifdef RV32_FETCH_PERF_EN
  logic [NH*32-1:0] perf_fetch_cnt;
  logic [31:0]      perf_stall_cnt;
`endif

  rv32_hart_fetch #(
    .NUM_HARTS  (NH),
    .PC_W       (32),
    .IMEM_ADDR_W(12),
    .RESET_ADDR (32'h0)
  ) dut (
    .rv32_io_clk    (clk),
    .rv32_io_rst    (rst),
    .rv32_io_program(prog),
    .bus            (bus.master)
`ifdef RV32_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Instruction memory: word n holds n.
  logic [31:0] imem [4096];
  initial for (int n = 0; n < 4096; n++) imem[n] = 32'(n);
  always @(posedge clk) bus.imem_rdata <= imem[bus.imem_raddr];

  logic [31:0] m_pc [NH];
  logic        m_mis [NH];
  int          m_rr;
  fetch_slot_t m_slot;
  sb_t         sb_q[$];

  task automatic model_reset();
    for (int i = 0; i < NH; i++) begin
      m_pc[i] = 32'h0;
      m_mis[i] = 1'b0;
    end
    m_rr = NH - 1;
    m_slot = '{valid: 1'b0, pc: 32'h0, hart: 3'd0, misalign: 1'b0};
  endtask

  task automatic model_update();
    fetch_slot_t nx;
    logic [31:0] tgt;
    logic        rmis, issue, byp;
    int          h;
    sb_t         e;
    tgt = {bus.redir_pc[31:2], 2'b00};
    rmis = (bus.redir_pc[1:0] != 2'b00);
    issue = !bus.stall && !prog && (bus.hart_en != '0);
    byp = 1'b0;
    h = m_rr;
    nx = m_slot;
    if (issue) begin
      for (int k = 0; k < NH; k++) begin
        h = (h + 1) % NH;
        if (bus.hart_en[h]) break;
      end
      byp = bus.redir_valid && (int'(bus.redir_hart) == h);
      nx.valid = 1'b1;
      nx.hart = 3'(h);
      nx.pc = byp ? tgt : m_pc[h];
      nx.misalign = byp ? rmis : m_mis[h];
      m_rr = h;
      m_pc[h] = nx.pc + 32'd4;
      m_mis[h] = 1'b0;
    end else if (!bus.stall || (bus.redir_valid && (bus.redir_hart == m_slot.hart))) begin
      nx.valid = 1'b0;
    end
    if (bus.redir_valid && !byp) begin
      m_pc[bus.redir_hart] = tgt;
      m_mis[bus.redir_hart] = rmis;
    end
    m_slot = nx;
    e.s = nx;
    e.due = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic cycle();
    model_update();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    sb_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      checks++;
      if (bus.f_valid !== e.s.valid) begin
        failures++;
        $display("FAIL sb_valid cyc=%0d got=%b want=%b", cyc, bus.f_valid, e.s.valid);
      end
      if (e.s.valid) begin
        checks++;
        if (bus.f_pc !== e.s.pc || bus.f_hart !== e.s.hart || bus.f_misalign !== e.s.misalign) begin
          failures++;
          $display("FAIL sb_slot cyc=%0d got pc=%h hart=%0d mis=%b want pc=%h hart=%0d mis=%b",
                   cyc, bus.f_pc, bus.f_hart, bus.f_misalign, e.s.pc, e.s.hart, e.s.misalign);
        end
        checks++;
        if (bus.f_instr !== 32'(e.s.pc[13:2])) begin
          failures++;
          $display("FAIL sb_instr cyc=%0d got=%h want=%h", cyc, bus.f_instr, 32'(e.s.pc[13:2]));
        end
      end
    end
  end

  task automatic test_reset();
    bus.hart_en = 8'hFF;
    bus.stall = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_hart = 3'd0;
    bus.redir_pc = 32'h0;
    prog = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.f_valid !== 1'b0) begin failures++; $display("FAIL reset_f_valid got=%b want=0", bus.f_valid); end
    checks++;
    if (bus.f_pc !== 32'h0) begin failures++; $display("FAIL reset_f_pc got=%h want=0", bus.f_pc); end
    checks++;
    if (bus.f_hart !== 3'd0) begin failures++; $display("FAIL reset_f_hart got=%0d want=0", bus.f_hart); end
    checks++;
    if (bus.f_misalign !== 1'b0) begin failures++; $display("FAIL reset_f_misalign got=%b want=0", bus.f_misalign); end
    checks++;
    if (bus.imem_raddr !== 12'h0) begin failures++; $display("FAIL reset_imem_raddr got=%h want=0", bus.imem_raddr); end
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    bus.hart_en = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      cycle();
      checks++;
      if (bus.f_valid !== 1'b1 || bus.f_hart !== 3'(i % 8) || bus.f_pc !== 32'((i / 8) * 4)) begin
        failures++;
        $display("FAIL rr_seq[%0d] got v=%b hart=%0d pc=%h want v=1 hart=%0d pc=%h",
                 i, bus.f_valid, bus.f_hart, bus.f_pc, i % 8, (i / 8) * 4);
      end
    end
  endtask

  task automatic test_mask();
    bus.hart_en = 8'b0000_0101;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if (bus.f_hart !== ((i % 2 == 0) ? 3'd0 : 3'd2) || bus.f_pc !== 32'(8 + 4 * (i / 2))) begin
        failures++;
        $display("FAIL mask_seq[%0d] got hart=%0d pc=%h want hart=%0d pc=%h",
                 i, bus.f_hart, bus.f_pc, (i % 2 == 0) ? 0 : 2, 8 + 4 * (i / 2));
      end
    end
    bus.hart_en = 8'hFF;
  endtask

  task automatic test_squash();
    bit found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      cycle();
      found = m_slot.valid && (m_slot.hart == 3'd3);
    end
    checks++;
    if (!found) begin failures++; $display("FAIL squash_find_h3 got=timeout want=hart3_in_slot"); end
    bus.stall = 1'b1;
    bus.redir_valid = 1'b1;
    bus.redir_hart = 3'd3;
    bus.redir_pc = 32'h100;
    cycle();
    bus.redir_valid = 1'b0;
    checks++;
    if (bus.f_valid !== 1'b0) begin failures++; $display("FAIL squash_valid got=%b want=0", bus.f_valid); end
    cycle();
    checks++;
    if (bus.f_valid !== 1'b0) begin failures++; $display("FAIL squash_hold got=%b want=0", bus.f_valid); end
    bus.stall = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      if (m_rr == 2) begin
        checks++;
        if (bus.imem_raddr !== 12'h040) begin
          failures++;
          $display("FAIL squash_raddr got=%h want=040", bus.imem_raddr);
        end
      end
      cycle();
      found = m_slot.valid && (m_slot.hart == 3'd3);
    end
    checks++;
    if (!found || bus.f_pc !== 32'h100 || bus.f_instr !== 32'h40) begin
      failures++;
      $display("FAIL squash_refetch got found=%b pc=%h instr=%h want pc=00000100 instr=00000040",
               found, bus.f_pc, bus.f_instr);
    end
  endtask

  task automatic test_redirect_bypass();
    bit found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      cycle();
      found = m_slot.valid && (m_slot.hart == 3'd7);
    end
    checks++;
    if (!found) begin failures++; $display("FAIL bypass_find_h7 got=timeout want=hart7_in_slot"); end
    bus.redir_valid = 1'b1;
    bus.redir_hart = 3'd0;
    bus.redir_pc = 32'h202;
    cycle();
    bus.redir_valid = 1'b0;
    checks++;
    if (bus.f_hart !== 3'd0 || bus.f_pc !== 32'h200 || bus.f_misalign !== 1'b1 || bus.f_instr !== 32'h80) begin
      failures++;
      $display("FAIL bypass_slot got hart=%0d pc=%h mis=%b instr=%h want hart=0 pc=00000200 mis=1 instr=00000080",
               bus.f_hart, bus.f_pc, bus.f_misalign, bus.f_instr);
    end
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      cycle();
      found = m_slot.valid && (m_slot.hart == 3'd0);
    end
    checks++;
    if (!found || bus.f_pc !== 32'h204 || bus.f_misalign !== 1'b0) begin
      failures++;
      $display("FAIL bypass_next got found=%b pc=%h mis=%b want pc=00000204 mis=0",
               found, bus.f_pc, bus.f_misalign);
    end
  endtask

  task automatic test_stall();
    fetch_slot_t hold;
    cycle();
    cycle();
    hold = m_slot;
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (bus.f_valid !== 1'b1 || bus.f_pc !== hold.pc || bus.f_hart !== hold.hart ||
          bus.f_instr !== 32'(hold.pc[13:2]) || bus.imem_raddr !== hold.pc[13:2]) begin
        failures++;
        $display("FAIL stall_hold[%0d] got v=%b pc=%h hart=%0d instr=%h raddr=%h want v=1 pc=%h hart=%0d raddr=%h",
                 i, bus.f_valid, bus.f_pc, bus.f_hart, bus.f_instr, bus.imem_raddr,
                 hold.pc, hold.hart, hold.pc[13:2]);
      end
    end
    bus.stall = 1'b0;
    cycle();
    checks++;
    if (bus.f_valid !== 1'b1 || bus.f_hart !== hold.hart + 3'd1) begin
      failures++;
      $display("FAIL stall_release got v=%b hart=%0d want v=1 hart=%0d", bus.f_valid, bus.f_hart, hold.hart + 3'd1);
    end
  endtask

  task automatic test_program();
    fetch_slot_t last;
    cycle();
    cycle();
    last = m_slot;
    prog = 1'b1;
    checks++;
    if (bus.f_valid !== 1'b1) begin failures++; $display("FAIL prog_drain got=%b want=1", bus.f_valid); end
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (bus.f_valid !== 1'b0) begin failures++; $display("FAIL prog_idle[%0d] got=%b want=0", i, bus.f_valid); end
    end
    prog = 1'b0;
    cycle();
    checks++;
    if (bus.f_valid !== 1'b1 || bus.f_hart !== last.hart + 3'd1) begin
      failures++;
      $display("FAIL prog_resume got v=%b hart=%0d want v=1 hart=%0d", bus.f_valid, bus.f_hart, last.hart + 3'd1);
    end
    for (int i = 0; i < 8; i++) cycle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_mask();
    test_squash();
    test_redirect_bypass();
    test_stall();
    test_program();
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d want=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
